// File: rtl/distance_pkg.sv
// Shared types and register offsets for the multi-channel ultrasonic distance interface.
package distance_pkg;

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_RISE,
        MEASURE,
        STORE,
        FAIL,
        GAP
    } state_e;

    localparam logic [15:0] DIST_STRIDE = 16'h0004;
    localparam logic [15:0] VALID_OFS   = 16'h0040;
    localparam logic [15:0] BROKEN_OFS  = 16'h0044;
    localparam logic [15:0] CAR_OFS     = 16'h0048;
    localparam logic [15:0] CHAN_OFS    = 16'h004C;

endpackage

// File: rtl/dist_echo_timer.sv
// Echo pulse timer: prescaled, saturating unit counter plus a per-phase timeout counter.
module dist_echo_timer #(
    parameter int DATA_W         = 16,
    parameter int CYC_PER_UNIT   = 2900,
    parameter int TIMEOUT_CYCLES = 1900000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              active,
    input  logic              measure,
    input  logic              echo_s,
    output logic              done,
    output logic              timeout,
    output logic [DATA_W-1:0] count
);

    localparam int PRE_W = ($clog2(CYC_PER_UNIT) > 0) ? $clog2(CYC_PER_UNIT) : 1;
    localparam int TO_W  = ($clog2(TIMEOUT_CYCLES) > 0) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(CYC_PER_UNIT - 1);
    localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [DATA_W-1:0] UNIT_MAX = '1;

    logic [PRE_W-1:0]  pre_q, pre_d;
    logic [DATA_W-1:0] unit_q, unit_d;
    logic [TO_W-1:0]   tcnt_q, tcnt_d;

    // start wins so each phase (WAIT_RISE, MEASURE) gets its own full timeout window
    always_comb begin
        pre_d  = pre_q;
        unit_d = unit_q;
        tcnt_d = tcnt_q;
        if (start) begin
            pre_d  = '0;
            unit_d = '0;
            tcnt_d = '0;
        end else begin
            if (active && tcnt_q != TO_LAST) tcnt_d = tcnt_q + TO_W'(1);
            if (measure && echo_s) begin
                if (pre_q == PRE_LAST) begin
                    pre_d = '0;
                    if (unit_q != UNIT_MAX) unit_d = unit_q + DATA_W'(1);
                end else begin
                    pre_d = pre_q + PRE_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q  <= '0;
            unit_q <= '0;
            tcnt_q <= '0;
        end else begin
            pre_q  <= pre_d;
            unit_q <= unit_d;
            tcnt_q <= tcnt_d;
        end
    end

    assign done    = measure && !echo_s;
    assign timeout = active && (tcnt_q == TO_LAST);
    assign count   = unit_q;

endmodule

// File: rtl/avalon_multi_distance_interface.sv
// N-channel ultrasonic distance sensor front end: one shared engine visits channels
// round-robin; results are exposed through a registered read-only Avalon window.
module avalon_multi_distance_interface
    import distance_pkg::*;
#(
    parameter int          N_CH           = 4,
    parameter int          DATA_W         = 16,
    parameter logic [15:0] BASE_ADDR      = 16'h0900,
    parameter int          TRIG_CYCLES    = 500,
    parameter int          CYC_PER_UNIT   = 2900,
    parameter int          TIMEOUT_CYCLES = 1900000,
    parameter int          GAP_CYCLES     = 3000000,
    parameter int          CAR_ON         = 50,
    parameter int          CAR_OFF        = 70
) (
    input  logic            clk,
    input  logic            reset_l,
    input  logic            io_select,
    input  logic [15:0]     address,
    output logic [15:0]     read_data,
    input  logic [N_CH-1:0] echo,
    output logic [N_CH-1:0] trigger
);

    localparam int CNT_MAX = (TRIG_CYCLES > GAP_CYCLES) ? TRIG_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0]  TRIG_LAST = CNT_W'(TRIG_CYCLES - 1);
    localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [DATA_W-1:0] CAR_ON_V  = DATA_W'(CAR_ON);
    localparam logic [DATA_W-1:0] CAR_OFF_V = DATA_W'(CAR_OFF);
    localparam logic [3:0]        CH_LAST   = 4'(N_CH - 1);

    logic [N_CH-1:0]             sync1_q, sync2_q;
    state_e                      state_q, state_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [3:0]                  ch_q, ch_d;
    logic [N_CH-1:0][DATA_W-1:0] dist_q;
    logic [N_CH-1:0]             valid_q, broken_q, car_q;
    logic [15:0]                 rdata_q, rdata_d;
    logic [15:0]                 ofs;
    logic                        echo_cur;
    logic                        tmr_start, tmr_active, tmr_measure, tmr_done, tmr_timeout;
    logic [DATA_W-1:0]           tmr_count;

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= echo;
            sync2_q <= sync1_q;
        end
    end

    always_comb begin
        echo_cur = 1'b0;
        for (int i = 0; i < N_CH; i++)
            if (ch_q == 4'(i)) echo_cur = sync2_q[i];
    end

    // An echo already high at the end of the trigger pulse skips WAIT_RISE entirely
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        ch_d    = ch_q;
        case (state_q)
            IDLE:      state_d = TRIG;
            TRIG:      if (cnt_q == TRIG_LAST) state_d = echo_cur ? MEASURE : WAIT_RISE;
            WAIT_RISE: begin
                if (echo_cur)         state_d = MEASURE;
                else if (tmr_timeout) state_d = FAIL;
            end
            MEASURE: begin
                if (tmr_done)         state_d = STORE;
                else if (tmr_timeout) state_d = FAIL;
            end
            STORE, FAIL: state_d = GAP;
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = IDLE;
                    ch_d    = (ch_q == CH_LAST) ? 4'd0 : ch_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (state_d != state_q) cnt_d = '0;
    end

    assign tmr_start   = (state_d != state_q) && (state_d == WAIT_RISE || state_d == MEASURE);
    assign tmr_active  = (state_q == WAIT_RISE) || (state_q == MEASURE);
    assign tmr_measure = (state_q == MEASURE);

    dist_echo_timer #(
        .DATA_W        (DATA_W),
        .CYC_PER_UNIT  (CYC_PER_UNIT),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst_n  (reset_l),
        .start  (tmr_start),
        .active (tmr_active),
        .measure(tmr_measure),
        .echo_s (echo_cur),
        .done   (tmr_done),
        .timeout(tmr_timeout),
        .count  (tmr_count)
    );

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ch_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ch_q    <= ch_d;
        end
    end

    // Decoded from registered state so an asynchronous reset drops the pulse at once
    always_comb begin
        trigger = '0;
        for (int i = 0; i < N_CH; i++)
            trigger[i] = (state_q == TRIG) && (ch_q == 4'(i));
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            dist_q   <= '0;
            valid_q  <= '0;
            broken_q <= '0;
            car_q    <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (ch_q == 4'(i) && state_q == STORE) begin
                    dist_q[i]   <= tmr_count;
                    valid_q[i]  <= 1'b1;
                    broken_q[i] <= 1'b0;
                    if (tmr_count < CAR_ON_V)       car_q[i] <= 1'b1;
                    else if (tmr_count > CAR_OFF_V) car_q[i] <= 1'b0;
                end else if (ch_q == 4'(i) && state_q == FAIL) begin
                    valid_q[i]  <= 1'b0;
                    broken_q[i] <= 1'b1;
                end
            end
        end
    end

    assign ofs = address - BASE_ADDR;

    always_comb begin
        rdata_d = '0;
        if (io_select) begin
            for (int k = 0; k < N_CH; k++)
                if (ofs == 16'(k) * DIST_STRIDE) rdata_d = 16'(dist_q[k]);
            case (ofs)
                VALID_OFS:  rdata_d = 16'(valid_q);
                BROKEN_OFS: rdata_d = 16'(broken_q);
                CAR_OFS:    rdata_d = 16'(car_q);
                CHAN_OFS:   rdata_d = {12'b0, ch_q};
                default:    ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) rdata_q <= '0;
        else          rdata_q <= rdata_d;
    end

    assign read_data = rdata_q;

endmodule

// File: tb/tb_avalon_multi_distance_interface.sv
// Randomised sensor-model bench: drives echo pulses per trigger and checks the register
// window against a per-channel reference of distance/valid/broken/car.
module tb_avalon_multi_distance_interface;

    localparam logic [15:0] BASE = 16'h0900;

    logic        clk = 1'b0;
    logic        reset_l, reset2_l, io_select;
    logic [15:0] address, read_data, read_data2;
    logic [1:0]  echo, trigger, echo2, trigger2;

    int checks = 0;
    int errors = 0;

    // reference model: result of the last completed measurement on each channel
    logic       exp_ch;
    logic [7:0] m_dist [2];
    logic [1:0] m_valid, m_broken, m_car;

    always #5 clk = ~clk;

    avalon_multi_distance_interface #(
        .N_CH(2), .DATA_W(8), .BASE_ADDR(16'h0900), .TRIG_CYCLES(4), .CYC_PER_UNIT(10),
        .TIMEOUT_CYCLES(200), .GAP_CYCLES(8), .CAR_ON(5), .CAR_OFF(7)
    ) dut (
        .clk(clk), .reset_l(reset_l), .io_select(io_select), .address(address),
        .read_data(read_data), .echo(echo), .trigger(trigger)
    );

    avalon_multi_distance_interface #(
        .N_CH(2), .DATA_W(8), .BASE_ADDR(16'h0900), .TRIG_CYCLES(4), .CYC_PER_UNIT(10),
        .TIMEOUT_CYCLES(5000), .GAP_CYCLES(8), .CAR_ON(5), .CAR_OFF(7)
    ) dut_sat (
        .clk(clk), .reset_l(reset2_l), .io_select(io_select), .address(address),
        .read_data(read_data2), .echo(echo2), .trigger(trigger2)
    );

    task automatic rd(input logic [15:0] a, input logic sel,
                      output logic [15:0] d, output logic [15:0] d2);
        @(negedge clk);
        io_select = sel;
        address   = a;
        @(negedge clk);
        d  = read_data;
        d2 = read_data2;
        io_select = 1'b0;
    endtask

    // waits for the next trigger pulse, checks its channel and width; returns at its falling edge
    task automatic wait_trig(input bit early);
        int n = 0;
        int width = 0;
        logic [1:0] want;
        want = exp_ch ? 2'b10 : 2'b01;
        while (trigger == 2'b00 && n < 800) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (trigger !== want) begin
            errors++;
            $display("FAIL trig_select ch%0d got %b want %b", exp_ch, trigger, want);
        end
        if (trigger == 2'b00) return;
        if (early) echo[exp_ch] = 1'b1;
        while (trigger != 2'b00 && width < 50) begin
            @(negedge clk);
            width++;
        end
        checks++;
        if (width != 4) begin
            errors++;
            $display("FAIL trig_width ch%0d got %0d want 4", exp_ch, width);
        end
    endtask

    task automatic check_regs();
        logic [15:0] d, d2;
        rd(BASE + 16'h0000, 1'b1, d, d2);
        checks++;
        if (d !== {8'h00, m_dist[0]}) begin errors++; $display("FAIL dist0 got %0d want %0d", d, m_dist[0]); end
        rd(BASE + 16'h0004, 1'b1, d, d2);
        checks++;
        if (d !== {8'h00, m_dist[1]}) begin errors++; $display("FAIL dist1 got %0d want %0d", d, m_dist[1]); end
        rd(BASE + 16'h0040, 1'b1, d, d2);
        checks++;
        if (d !== {14'b0, m_valid}) begin errors++; $display("FAIL valid got %h want %b", d, m_valid); end
        rd(BASE + 16'h0044, 1'b1, d, d2);
        checks++;
        if (d !== {14'b0, m_broken}) begin errors++; $display("FAIL broken got %h want %b", d, m_broken); end
        rd(BASE + 16'h0048, 1'b1, d, d2);
        checks++;
        if (d !== {14'b0, m_car}) begin errors++; $display("FAIL car got %h want %b", d, m_car); end
        rd(BASE + 16'h004C, 1'b1, d, d2);
        checks++;
        if (d !== {15'b0, exp_ch}) begin errors++; $display("FAIL chan got %0d want %0d", d, exp_ch); end
        rd(BASE + 16'h0050, 1'b1, d, d2);
        checks++;
        if (d !== 16'h0000) begin errors++; $display("FAIL unmapped got %h want 0", d); end
        rd(BASE + 16'h0040, 1'b0, d, d2);
        checks++;
        if (d !== 16'h0000) begin errors++; $display("FAIL deselected got %h want 0", d); end
    endtask

    // kind: 0 normal echo, 1 no echo, 2 echo already high at trigger end, 3 echo stuck high
    task automatic measure(input int kind, input int d);
        logic ch;
        int len;
        ch  = exp_ch;
        len = d * 10 + 5;
        wait_trig(kind == 2);
        fork
            begin
                if (kind == 0 || kind == 3) begin
                    repeat ($urandom_range(20, 40)) @(negedge clk);
                    echo[ch] = 1'b1;
                    repeat ((kind == 3) ? 208 : len) @(negedge clk);
                    echo[ch] = 1'b0;
                end else if (kind == 2) begin
                    repeat (len) @(negedge clk);
                    echo[ch] = 1'b0;
                end
            end
            check_regs();
        join
        if (kind == 0 || kind == 2) begin
            m_dist[ch]   = 8'(d);
            m_valid[ch]  = 1'b1;
            m_broken[ch] = 1'b0;
            if (d < 5)      m_car[ch] = 1'b1;
            else if (d > 7) m_car[ch] = 1'b0;
        end else begin
            m_valid[ch]  = 1'b0;
            m_broken[ch] = 1'b1;
        end
        exp_ch = ~ch;
    endtask

    task automatic test_reset();
        reset_l = 1'b0; reset2_l = 1'b0; io_select = 1'b0; address = '0;
        echo = '0; echo2 = '0;
        exp_ch = 1'b0;
        m_dist[0] = '0; m_dist[1] = '0;
        m_valid = '0; m_broken = '0; m_car = '0;
        repeat (3) @(negedge clk);
        io_select = 1'b1;
        address   = BASE + 16'h004C;
        @(negedge clk);
        checks++;
        if (trigger !== 2'b00 || trigger2 !== 2'b00) begin
            errors++; $display("FAIL reset_trigger got %b/%b want 00", trigger, trigger2);
        end
        checks++;
        if (read_data !== 16'h0000) begin errors++; $display("FAIL reset_rdata got %h want 0", read_data); end
        io_select = 1'b0;
        reset_l   = 1'b1;
    endtask

    task automatic test_directed();
        measure(0, 3);
        measure(0, $urandom_range(0, 12));
        measure(1, 0);
        measure(0, $urandom_range(0, 12));
        measure(0, 6);
        measure(3, 0);
        measure(0, 8);
        measure(2, $urandom_range(3, 12));
        measure(0, 6);
        measure(0, $urandom_range(0, 12));
        measure(0, 4);
    endtask

    task automatic test_random();
        for (int i = 0; i < 10; i++) begin
            int kind;
            kind = $urandom_range(0, 3);
            measure(kind, (kind == 2) ? $urandom_range(3, 12) : $urandom_range(0, 12));
        end
        wait_trig(1'b0);
        check_regs();
    endtask

    task automatic test_saturation();
        logic [15:0] d, d2;
        int n = 0;
        @(negedge clk);
        reset2_l = 1'b1;
        while (trigger2 != 2'b01 && n < 100) begin @(negedge clk); n++; end
        while (trigger2 != 2'b00 && n < 100) begin @(negedge clk); n++; end
        checks++;
        if (n >= 100) begin errors++; $display("FAIL sat_trigger got %b want pulse on ch0", trigger2); end
        echo2[0] = 1'b1;
        repeat (3000) @(negedge clk);
        echo2[0] = 1'b0;
        repeat (10) @(negedge clk);
        rd(BASE + 16'h0000, 1'b1, d, d2);
        checks++;
        if (d2 !== 16'h00FF) begin errors++; $display("FAIL sat_dist got %0d want 255", d2); end
        rd(BASE + 16'h0044, 1'b1, d, d2);
        checks++;
        if (d2 !== 16'h0000) begin errors++; $display("FAIL sat_broken got %h want 0", d2); end
    endtask

    task automatic test_reset_mid();
        logic [15:0] d, d2;
        int n = 0;
        while (trigger == 2'b00 && n < 800) begin @(negedge clk); n++; end
        @(negedge clk);
        reset_l = 1'b0;
        #1;
        checks++;
        if (trigger !== 2'b00) begin errors++; $display("FAIL rst_mid_trigger got %b want 00", trigger); end
        repeat (2) @(negedge clk);
        reset_l = 1'b1;
        for (int a = 0; a < 6; a++) begin
            logic [15:0] addr;
            addr = (a < 2) ? BASE + 16'(4 * a) : BASE + 16'h0040 + 16'(4 * (a - 2));
            rd(addr, 1'b1, d, d2);
            checks++;
            if (d !== 16'h0000) begin errors++; $display("FAIL rst_mid_reg addr %h got %h want 0", addr, d); end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_saturation();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired after %0t", $time);
        $fatal(1);
    end

endmodule
